// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// instruction classes, ALU/immediate-extension codes and the latched decode record.
package control_pkg;

   typedef enum logic [2:0] {
      S_RST  = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b100000;
   localparam logic [5:0] OP_LI    = 6'b111000;
   localparam logic [5:0] OP_LUI   = 6'b111001;
   localparam logic [5:0] OP_ADDI  = 6'b110000;
   localparam logic [5:0] OP_ANDI  = 6'b110010;
   localparam logic [5:0] OP_ORI   = 6'b110011;
   localparam logic [5:0] OP_B     = 6'b111111;
   localparam logic [5:0] OP_BEQ   = 6'b000000;
   localparam logic [5:0] OP_BNE   = 6'b000001;
   localparam logic [5:0] OP_LB    = 6'b000011;
   localparam logic [5:0] OP_LW    = 6'b001111;
   localparam logic [5:0] OP_SB    = 6'b000111;
   localparam logic [5:0] OP_SW    = 6'b011111;

   typedef enum logic [2:0] {
      CL_ILL = 3'd0,
      CL_R   = 3'd1,
      CL_IMM = 3'd2,
      CL_BR  = 3'd3,
      CL_LD  = 3'd4,
      CL_ST  = 3'd5
   } cls_e;

   typedef enum logic [1:0] {
      BR_NONE   = 2'd0,
      BR_ALWAYS = 2'd1,
      BR_EQ     = 2'd2,
      BR_NE     = 2'd3
   } br_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;

   localparam logic [1:0] IMM_SEXT     = 2'b00;
   localparam logic [1:0] IMM_ZEXT     = 2'b01;
   localparam logic [1:0] IMM_HI       = 2'b10;
   localparam logic [1:0] IMM_SEXT_SH2 = 2'b11;

   typedef struct packed {
      cls_e       cls;
      br_e        br;
      logic [3:0] alu_func;
      logic [1:0] imm_ext;
      logic       rf_b_sel;
      logic       byte_op;
   } dec_t;

   localparam dec_t DEC_ILL = '{cls: CL_ILL, br: BR_NONE, alu_func: ALU_ADD,
                                imm_ext: IMM_SEXT, rf_b_sel: 1'b0, byte_op: 1'b0};

   function automatic logic br_taken(input br_e br, input logic zero);
      case (br)
         BR_ALWAYS: br_taken = 1'b1;
         BR_EQ:     br_taken = zero;
         BR_NE:     br_taken = ~zero;
         default:   br_taken = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/control_mc_if.sv
// Control-to-datapath bundle: IR/flag inputs into the controller and every
// datapath/register-file control it drives.
interface control_mc_if;
   logic [31:0] Instr;
   logic        Zero;
   logic        PC_LdEn;
   logic        PC_sel;
   logic        IR_LdEn;
   logic        AB_LdEn;
   logic        RF_B_sel;
   logic        RF_WrEn;
   logic        RF_WrData_sel;
   logic        ALU_Bin_sel;
   logic [3:0]  ALU_func;
   logic [1:0]  ImmExt;
   logic        MEM_WrEn;
   logic        ByteOp;

   modport master (
      input  Instr, Zero,
      output PC_LdEn, PC_sel, IR_LdEn, AB_LdEn, RF_B_sel, RF_WrEn,
             RF_WrData_sel, ALU_Bin_sel, ALU_func, ImmExt, MEM_WrEn, ByteOp
   );

   modport slave (
      output Instr, Zero,
      input  PC_LdEn, PC_sel, IR_LdEn, AB_LdEn, RF_B_sel, RF_WrEn,
             RF_WrData_sel, ALU_Bin_sel, ALU_func, ImmExt, MEM_WrEn, ByteOp
   );
endinterface

// File: rtl/control_decode.sv
// Combinational instruction decode: opcode/func to class, branch kind,
// ALU operation, immediate extension, second read-address select and byte flag.
module control_decode
   import control_pkg::*;
#(
   parameter int OPW = 6,
   parameter int FNW = 6
) (
   input  logic [OPW-1:0] opcode_i,
   input  logic [FNW-1:0] func_i,
   output dec_t           dec_o
);

   logic unused_func;
   assign unused_func = ^func_i[FNW-1:4];

   always_comb begin
      dec_o = DEC_ILL;
      case (opcode_i)
         OP_RTYPE: begin
            dec_o.cls      = CL_R;
            dec_o.alu_func = func_i[3:0];
         end
         OP_LI, OP_ADDI: begin
            dec_o.cls      = CL_IMM;
            dec_o.rf_b_sel = 1'b1;
         end
         OP_LUI: begin
            dec_o.cls      = CL_IMM;
            dec_o.imm_ext  = IMM_HI;
            dec_o.rf_b_sel = 1'b1;
         end
         OP_ANDI, OP_ORI: begin
            dec_o.cls      = CL_IMM;
            dec_o.alu_func = (opcode_i == OP_ANDI) ? ALU_AND : ALU_OR;
            dec_o.imm_ext  = IMM_ZEXT;
            dec_o.rf_b_sel = 1'b1;
         end
         OP_B, OP_BEQ, OP_BNE: begin
            dec_o.cls      = CL_BR;
            dec_o.br       = (opcode_i == OP_B)   ? BR_ALWAYS :
                             (opcode_i == OP_BEQ) ? BR_EQ : BR_NE;
            dec_o.alu_func = ALU_SUB;
            dec_o.imm_ext  = IMM_SEXT_SH2;
            dec_o.rf_b_sel = 1'b1;
         end
         OP_LB, OP_LW: begin
            dec_o.cls     = CL_LD;
            dec_o.byte_op = (opcode_i == OP_LB);
         end
         OP_SB, OP_SW: begin
            dec_o.cls      = CL_ST;
            dec_o.byte_op  = (opcode_i == OP_SB);
            dec_o.rf_b_sel = 1'b1;
         end
         default: dec_o = DEC_ILL;
      endcase
   end

endmodule

// File: rtl/control_mc.sv
// Multi-cycle control FSM for the datapath and register file; sole source of RF WrEn.
//   state  | meaning
//   S_RST  | held in reset, all controls low
//   FETCH  | load IR
//   DECODE | latch A/B and decode; illegal opcode retires as a nop
//   EXEC   | ALU operation; branches resolve and retire here
//   MEM    | data memory access; stores retire here
//   WB     | register-file write, PC advance
module control_mc
   import control_pkg::*;
#(
   parameter int OPW = 6,
   parameter int FNW = 6
) (
   input  logic         Clk,
   input  logic         Rst,
   control_mc_if.master bus
);

   state_e state_q;
   dec_t   dec_q;
   dec_t   dec_live;

   logic unused_instr;
   assign unused_instr = ^bus.Instr[31-OPW:FNW];

   control_decode #(.OPW(OPW), .FNW(FNW)) u_decode (
      .opcode_i (bus.Instr[31 -: OPW]),
      .func_i   (bus.Instr[FNW-1:0]),
      .dec_o    (dec_live)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= S_RST;
         dec_q   <= DEC_ILL;
      end else begin
         case (state_q)
            S_RST:  state_q <= FETCH;
            FETCH:  state_q <= DECODE;
            DECODE: begin
               dec_q   <= dec_live;
               state_q <= (dec_live.cls == CL_ILL) ? FETCH : EXEC;
            end
            EXEC: begin
               case (dec_q.cls)
                  CL_R, CL_IMM: state_q <= WB;
                  CL_LD, CL_ST: state_q <= MEM;
                  default:      state_q <= FETCH;
               endcase
            end
            MEM:     state_q <= (dec_q.cls == CL_ST) ? FETCH : WB;
            WB:      state_q <= FETCH;
            default: state_q <= S_RST;
         endcase
      end
   end

   always_comb begin
      bus.PC_LdEn       = 1'b0;
      bus.PC_sel        = 1'b0;
      bus.IR_LdEn       = 1'b0;
      bus.AB_LdEn       = 1'b0;
      bus.RF_B_sel      = 1'b0;
      bus.RF_WrEn       = 1'b0;
      bus.RF_WrData_sel = 1'b0;
      bus.ALU_Bin_sel   = 1'b0;
      bus.ALU_func      = ALU_ADD;
      bus.ImmExt        = IMM_SEXT;
      bus.MEM_WrEn      = 1'b0;
      bus.ByteOp        = 1'b0;
      case (state_q)
         FETCH: bus.IR_LdEn = 1'b1;
         DECODE: begin
            // IR was loaded on the edge into DECODE, so only the live decode is current here
            bus.AB_LdEn  = 1'b1;
            bus.RF_B_sel = dec_live.rf_b_sel;
            bus.PC_LdEn  = (dec_live.cls == CL_ILL);
         end
         EXEC: begin
            bus.ALU_func    = dec_q.alu_func;
            bus.ImmExt      = dec_q.imm_ext;
            bus.RF_B_sel    = dec_q.rf_b_sel;
            bus.ALU_Bin_sel = (dec_q.cls == CL_IMM) || (dec_q.cls == CL_LD) ||
                              (dec_q.cls == CL_ST);
            if (dec_q.cls == CL_BR) begin
               bus.PC_LdEn = 1'b1;
               bus.PC_sel  = br_taken(dec_q.br, bus.Zero);
            end
         end
         MEM: begin
            bus.ByteOp   = dec_q.byte_op;
            bus.RF_B_sel = dec_q.rf_b_sel;
            if (dec_q.cls == CL_ST) begin
               bus.MEM_WrEn = 1'b1;
               bus.PC_LdEn  = 1'b1;
            end
         end
         WB: begin
            bus.RF_WrEn       = 1'b1;
            bus.RF_WrData_sel = (dec_q.cls == CL_LD);
            bus.RF_B_sel      = dec_q.rf_b_sel;
            bus.PC_LdEn       = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_mc.sv
// Bench for control_mc: a per-instruction model of the cycle-by-cycle control
// outputs, checked every cycle, plus FETCH-to-FETCH latency checks against fixed counts.
module tb_control_mc;

   typedef struct packed {
      logic       pc_ld;
      logic       pc_sel;
      logic       ir_ld;
      logic       ab_ld;
      logic       rf_b;
      logic       rf_wr;
      logic       wd_sel;
      logic       bin;
      logic [3:0] alu;
      logic [1:0] imm;
      logic       mem_wr;
      logic       byte_op;
   } vec_t;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   control_mc_if bus();

   control_mc dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   vec_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   lat_cnt  = 0;
   int   last_lat = 0;
   int   prev_lat = 0;

   // Expected output vectors, one per cycle, from FETCH up to the instruction's last state.
   function automatic void push_seq(input logic [31:0] ins, input logic z, input bit rst_mem);
      logic [5:0] op;
      int         cls;          // 0 ILL, 1 R, 2 IMM, 3 BR, 4 LD, 5 ST
      logic [3:0] alu;
      logic [1:0] imm;
      logic       taken;
      logic       bsel;
      logic       byt;
      vec_t       v;
      op    = ins[31:26];
      alu   = 4'd0;
      imm   = 2'd0;
      taken = 1'b0;
      byt   = 1'b0;
      case (op)
         6'b100000: begin cls = 1; alu = ins[3:0]; end
         6'b111000, 6'b110000: cls = 2;
         6'b111001: begin cls = 2; imm = 2'b10; end
         6'b110010: begin cls = 2; alu = 4'b0010; imm = 2'b01; end
         6'b110011: begin cls = 2; alu = 4'b0011; imm = 2'b01; end
         6'b111111: begin cls = 3; alu = 4'b0001; imm = 2'b11; taken = 1'b1; end
         6'b000000: begin cls = 3; alu = 4'b0001; imm = 2'b11; taken = z; end
         6'b000001: begin cls = 3; alu = 4'b0001; imm = 2'b11; taken = ~z; end
         6'b000011: begin cls = 4; byt = 1'b1; end
         6'b001111: cls = 4;
         6'b000111: begin cls = 5; byt = 1'b1; end
         6'b011111: cls = 5;
         default:   cls = 0;
      endcase
      bsel = (cls == 2) || (cls == 3) || (cls == 5);

      v = '0; v.ir_ld = 1'b1;
      exp_q.push_back(v);

      v = '0; v.ab_ld = 1'b1; v.rf_b = bsel;
      if (cls == 0) begin
         v.pc_ld = 1'b1;
         exp_q.push_back(v);
         return;
      end
      exp_q.push_back(v);

      v = '0; v.alu = alu; v.imm = imm; v.rf_b = bsel;
      v.bin = (cls == 2) || (cls == 4) || (cls == 5);
      if (cls == 3) begin
         v.pc_ld  = 1'b1;
         v.pc_sel = taken;
         exp_q.push_back(v);
         return;
      end
      exp_q.push_back(v);

      if (cls == 4 || cls == 5) begin
         v = '0; v.byte_op = byt; v.rf_b = bsel;
         if (cls == 5) begin
            v.mem_wr = 1'b1;
            v.pc_ld  = 1'b1;
         end
         exp_q.push_back(v);
         if (rst_mem) begin
            v = '0;
            exp_q.push_back(v);
            return;
         end
         if (cls == 5) return;
      end

      v = '0; v.rf_wr = 1'b1; v.wd_sel = (cls == 4); v.pc_ld = 1'b1; v.rf_b = bsel;
      exp_q.push_back(v);
   endfunction

   always @(negedge Clk) begin
      vec_t a;
      vec_t e;
      a.pc_ld   = bus.PC_LdEn;
      a.pc_sel  = bus.PC_sel;
      a.ir_ld   = bus.IR_LdEn;
      a.ab_ld   = bus.AB_LdEn;
      a.rf_b    = bus.RF_B_sel;
      a.rf_wr   = bus.RF_WrEn;
      a.wd_sel  = bus.RF_WrData_sel;
      a.bin     = bus.ALU_Bin_sel;
      a.alu     = bus.ALU_func;
      a.imm     = bus.ImmExt;
      a.mem_wr  = bus.MEM_WrEn;
      a.byte_op = bus.ByteOp;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL ctrl_vec t=%0t actual=%h required=%h (pc_ld,pc_sel,ir,ab,rfb,rfwr,wdsel,bin,alu[4],imm[2],memwr,byte)",
                     $time, a, e);
         end
      end
      if (a.ir_ld === 1'b1) begin
         last_lat = lat_cnt;
         lat_cnt  = 1;
      end else begin
         lat_cnt++;
      end
   end

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
      mk = {op, 20'h5A3C7, fn};
   endfunction

   // Called one posedge+2 into FETCH; returns one posedge+2 into the next FETCH.
   task automatic run(input logic [31:0] ins, input logic z, input bit rst_mem, input int lat);
      int n;
      bus.Instr = ins;
      bus.Zero  = z;
      push_seq(ins, z, rst_mem);
      @(negedge Clk); #1;
      if (prev_lat > 0) begin
         checks++;
         if (last_lat != prev_lat) begin
            errors++;
            $display("FAIL latency t=%0t actual=%0d required=%0d", $time, last_lat, prev_lat);
         end
      end
      @(posedge Clk); #2;
      @(posedge Clk); #2;
      bus.Instr = ~ins;
      if (rst_mem) begin
         @(posedge Clk); #2;
         Rst = 1'b1;
         @(posedge Clk); #2;
         Rst = 1'b0;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge Clk); #2;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL seq_timeout t=%0t actual=%0d pending required=0", $time, exp_q.size());
         exp_q.delete();
      end
      prev_lat = rst_mem ? 0 : lat;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t z;
      z = '0;
      bus.Instr = 32'd0;
      bus.Zero  = 1'b0;
      Rst       = 1'b1;
      @(posedge Clk); #2;
      for (int i = 0; i < 3; i++) exp_q.push_back(z);
      @(posedge Clk); #2;
      @(posedge Clk); #2;
      Rst = 1'b0;
      @(posedge Clk); #2;

      run(mk(6'b100000, 6'b110000), 1'b0, 1'b0, 4);  // R add
      run(mk(6'b100000, 6'b000011), 1'b0, 1'b0, 4);  // R, func low bits 0011
      run(mk(6'b001111, 6'b000000), 1'b0, 1'b0, 5);  // lw
      run(mk(6'b000011, 6'b000000), 1'b0, 1'b0, 5);  // lb
      run(mk(6'b000111, 6'b000000), 1'b0, 1'b0, 4);  // sb
      run(mk(6'b011111, 6'b000000), 1'b0, 1'b0, 4);  // sw
      run(mk(6'b000000, 6'b000000), 1'b1, 1'b0, 3);  // beq taken
      run(mk(6'b000000, 6'b000000), 1'b0, 1'b0, 3);  // beq not taken
      run(mk(6'b000001, 6'b000000), 1'b1, 1'b0, 3);  // bne not taken
      run(mk(6'b000001, 6'b000000), 1'b0, 1'b0, 3);  // bne taken
      run(mk(6'b111111, 6'b000000), 1'b0, 1'b0, 3);  // b
      run(mk(6'b111000, 6'b000000), 1'b0, 1'b0, 4);  // li
      run(mk(6'b111001, 6'b000000), 1'b0, 1'b0, 4);  // lui
      run(mk(6'b110000, 6'b000000), 1'b0, 1'b0, 4);  // addi
      run(mk(6'b110010, 6'b000000), 1'b0, 1'b0, 4);  // andi
      run(mk(6'b110011, 6'b000000), 1'b0, 1'b0, 4);  // ori
      run(mk(6'b010101, 6'b000000), 1'b0, 1'b0, 2);  // illegal
      run(mk(6'b011111, 6'b000000), 1'b0, 1'b1, 0);  // sw, reset during MEM
      run(mk(6'b010101, 6'b000000), 1'b0, 1'b0, 2);  // illegal after reset
      run(mk(6'b100000, 6'b000010), 1'b0, 1'b0, 4);  // R, closes previous latency
      run(mk(6'b001111, 6'b000000), 1'b0, 1'b0, 5);  // lw, closes previous latency

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_mc.md
Name: control_mc

Overview:
- Multi-cycle control FSM that sits directly upstream of the register file.
- It decodes the instruction held in the instruction register and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- It drives the register-file write enable, the write-data select and the second read-address select, plus the PC, IR, ALU and memory controls of the multi-cycle datapath.
- It is the only source of the register file's WrEn.

Parameters:
- OPW, 6, opcode field width (Instr[31:26]).
- FNW, 6, function field width (Instr[5:0]).

Ports:
- Clk  in  1  rising-edge clock, same clock as the register file.
- Rst  in  1  synchronous, active-high reset.
- Instr  in  32  IR contents; valid from the DECODE state onward.
- Zero  in  1  ALU zero flag; sampled only in EXEC of a branch.
- PC_LdEn  out  1  PC register load.
- PC_sel  out  1  0 = PC+4, 1 = PC+4+(SignExt(imm)<<2).
- IR_LdEn  out  1  IR load.
- AB_LdEn  out  1  latch RF Dout1/Dout2 into the A/B regs.
- RF_B_sel  out  1  0 = Ard2 from Instr[15:11]; 1 = Ard2 from Instr[20:16].
- RF_WrEn  out  1  drives register-file WrEn.
- RF_WrData_sel  out  1  0 = ALU result reg; 1 = memory data reg.
- ALU_Bin_sel  out  1  0 = B reg; 1 = extended immediate.
- ALU_func  out  4  ALU operation.
- ImmExt  out  2  00 sign-ext; 01 zero-ext; 10 imm<<16 zero-fill; 11 sign-ext<<2.
- MEM_WrEn  out  1  data memory write.
- ByteOp  out  1  1 = byte access (lb/sb).

Behaviour:
- Opcodes (Instr[31:26]):
  - R-type 100000.
  - li 111000, lui 111001, addi 110000, andi 110010, ori 110011.
  - b 111111, beq 000000, bne 000001.
  - lb 000011, lw 001111, sb 000111, sw 011111.
  - Any other opcode is illegal.
- Classes: R, IMM (li/lui/addi/andi/ori), BR, LD (lb/lw), ST (sb/sw), ILL.
- The class, byte flag and ALU/ImmExt/RF_B_sel decode are latched in DECODE into an internal register. They hold until the next DECODE, so later IR changes do not affect an instruction in flight.
- States: S_RST, FETCH, DECODE, EXEC, MEM, WB. Outputs are Moore functions of state and the latched decode, except PC_sel in EXEC/BR, which is combinational on Zero.
- Any Rst=1 at a rising edge:
  - Next state is S_RST and the latched decode is cleared to ILL.
  - In S_RST every output is 0.
  - S_RST goes to FETCH on the first edge with Rst=0.
- Rst overrides every other transition, including mid-MEM of a store: MEM_WrEn is 0 from the cycle after the reset edge.
- FETCH: IR_LdEn=1. Next state DECODE.
- DECODE: AB_LdEn=1; RF_B_sel is driven from the live decode. Next state:
  - EXEC for R, IMM, BR, LD, ST.
  - FETCH for ILL, with PC_LdEn=1 and PC_sel=0 (treated as a nop).
- EXEC:
  - ALU_func:
    - R: func[3:0].
    - add 0000: addi, li, lui, LD, ST.
    - andi 0010, ori 0011.
    - BR: sub 0001.
  - ALU_Bin_sel = 1 for IMM, LD, ST.
  - ImmExt:
    - 00: addi, li, LD, ST.
    - 01: andi, ori.
    - 10: lui.
    - 11: BR.
  - RF_B_sel = 1 for IMM, BR, ST.
  - Next state: R/IMM -> WB; LD/ST -> MEM; BR -> FETCH.
  - For BR, PC_LdEn=1 and PC_sel = 1 when taken:
    - b: always taken.
    - beq: taken when Zero=1.
    - bne: taken when Zero=0.
- MEM:
  - ByteOp=1 for lb/sb.
  - ST: MEM_WrEn=1 for exactly one cycle, plus PC_LdEn=1 and PC_sel=0; next state FETCH.
  - LD: next state WB.
- WB:
  - RF_WrEn=1 for exactly one cycle.
  - RF_WrData_sel = 1 for LD, else 0.
  - PC_LdEn=1, PC_sel=0; next state FETCH.
- Latency in cycles, FETCH to FETCH: R/IMM 4, LD 5, ST 4, BR 3, ILL 2.
- RF_WrEn, MEM_WrEn, PC_LdEn and IR_LdEn are never high in the same cycle except the PC_LdEn+RF_WrEn and PC_LdEn+MEM_WrEn pairs above.
- RF_WrEn is never asserted for BR, ST or ILL.

Decomposition:
- Shared package control_pkg holds:
  - state encoding: 3-bit one-hot-safe binary, S_RST=000.
  - opcode constants.
  - class encoding.
  - ALU_func and ImmExt constants.
- One sub-module: control_decode, purely combinational. It maps opcode/func to class, ALU_func, ImmExt, RF_B_sel and ByteOp, and is instantiated once before the DECODE latch.

Test Plan:
- Rst held 3 cycles, then released -> all outputs 0 while in S_RST; IR_LdEn=1 on the first cycle after S_RST.
- R-type add (opcode 100000, func 110000) -> DECODE AB_LdEn=1; EXEC ALU_func=0000, ALU_Bin_sel=0; WB RF_WrEn=1, RF_WrData_sel=0, PC_LdEn=1; 4 cycles total.
- lw (001111) -> EXEC ALU_Bin_sel=1, ImmExt=00; MEM ByteOp=0; WB RF_WrEn=1, RF_WrData_sel=1; 5 cycles total.
- sb (000111) -> MEM MEM_WrEn=1, ByteOp=1, RF_B_sel=1; RF_WrEn stays 0 throughout.
- beq with Zero=1 -> EXEC PC_LdEn=1, PC_sel=1.
- bne with Zero=1 -> EXEC PC_LdEn=1, PC_sel=0; 3 cycles total.
- sw with Rst asserted during MEM -> MEM_WrEn=0 on the next cycle; illegal opcode 010101 -> DECODE goes to FETCH with PC_LdEn=1 and RF_WrEn never asserted.
